// File: rtl/parking_zone_counter.sv
// Per-zone saturating occupancy counters with preset, clear, a registered running
// total, decoded occupancy flags and overflow/underflow error reporting.
module parking_zone_counter #(
  parameter int N_ZONES = 4,
  parameter int WIDTH   = 5,
  parameter int CAP     = 25,
  parameter int WARN    = 20,
  localparam int ZW     = (N_ZONES > 1) ? $clog2(N_ZONES) : 1,
  localparam int TW     = WIDTH + ZW
) (
  input  logic                       CLOCK_50,
  input  logic                       RSTN,
  input  logic [N_ZONES-1:0]         INC,
  input  logic [N_ZONES-1:0]         DEC,
  input  logic                       CLR,
  input  logic                       LOAD_EN,
  input  logic [ZW-1:0]              LOAD_ZONE,
  input  logic [WIDTH-1:0]           LOAD_VAL,
  output logic [N_ZONES*WIDTH-1:0]   cntNum,
  output logic [TW-1:0]              total,
  output logic [N_ZONES-1:0]         full,
  output logic [N_ZONES-1:0]         empty,
  output logic [N_ZONES-1:0]         warn,
  output logic                       lot_full,
  output logic [N_ZONES-1:0]         err_ovf,
  output logic [N_ZONES-1:0]         err_unf,
  output logic                       err_sticky
);

  localparam logic [WIDTH-1:0] CAP_W  = WIDTH'(CAP);
  localparam logic [WIDTH-1:0] WARN_W = WIDTH'(WARN);

  generate
    if (N_ZONES < 1 || N_ZONES > 16) begin : g_bad_zones
      $error("parking_zone_counter: N_ZONES must be 1..16");
    end
    if (CAP >= 2**WIDTH) begin : g_bad_cap
      $error("parking_zone_counter: CAP must be < 2**WIDTH");
    end
    if (WARN > CAP) begin : g_bad_warn
      $error("parking_zone_counter: WARN must be <= CAP");
    end
  endgenerate

  logic                     load_valid;
  logic                     load_over;
  logic                     load_err;
  logic [WIDTH-1:0]         load_val_sat;
  logic [N_ZONES*WIDTH-1:0] cnt_next_flat;
  logic [N_ZONES-1:0]       ovf_next;
  logic [N_ZONES-1:0]       unf_next;
  logic [TW-1:0]            total_next;
  logic [TW-1:0]            total_reg;
  logic [N_ZONES-1:0]       err_ovf_reg;
  logic [N_ZONES-1:0]       err_unf_reg;
  logic                     err_sticky_reg;
  logic                     err_sticky_next;

  assign load_valid   = LOAD_EN && (32'(LOAD_ZONE) < N_ZONES);
  assign load_over    = LOAD_VAL > CAP_W;
  assign load_val_sat = load_over ? CAP_W : LOAD_VAL;
  // An out-of-range zone or an over-capacity preset is flagged even though the
  // clamped value is still written.
  assign load_err     = LOAD_EN && ((32'(LOAD_ZONE) >= N_ZONES) || load_over);

  genvar gi;
  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
      logic [WIDTH-1:0] count_reg;
      logic [WIDTH-1:0] count_next;
      logic             ovf_z;
      logic             unf_z;

      always_comb begin
        count_next = count_reg;
        ovf_z      = 1'b0;
        unf_z      = 1'b0;
        if (CLR) begin
          count_next = '0;
        end else if (load_valid && (32'(LOAD_ZONE) == gi)) begin
          count_next = load_val_sat;
        end else if (INC[gi] && !DEC[gi]) begin
          if (count_reg < CAP_W) count_next = count_reg + WIDTH'(1);
          else                   ovf_z      = 1'b1;
        end else if (DEC[gi] && !INC[gi]) begin
          if (count_reg != '0)   count_next = count_reg - WIDTH'(1);
          else                   unf_z      = 1'b1;
        end
      end

      always_ff @(posedge CLOCK_50 or negedge RSTN) begin
        if (!RSTN) count_reg <= '0;
        else       count_reg <= count_next;
      end

      assign cnt_next_flat[gi*WIDTH +: WIDTH] = count_next;
      assign cntNum[gi*WIDTH +: WIDTH]        = count_reg;
      assign ovf_next[gi]                     = ovf_z;
      assign unf_next[gi]                     = unf_z;
      assign full[gi]                         = (count_reg == CAP_W);
      assign empty[gi]                        = (count_reg == '0);
      assign warn[gi]                         = (count_reg >= WARN_W);
    end
  endgenerate

  // Summing the next-state counts keeps the registered total in lockstep with cntNum.
  always_comb begin
    total_next = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      total_next = total_next + TW'(cnt_next_flat[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    err_sticky_next = err_sticky_reg | (|ovf_next) | (|unf_next) | load_err;
    if (CLR) err_sticky_next = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN) begin
    if (!RSTN) begin
      total_reg      <= '0;
      err_ovf_reg    <= '0;
      err_unf_reg    <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      total_reg      <= total_next;
      err_ovf_reg    <= ovf_next;
      err_unf_reg    <= unf_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign total      = total_reg;
  assign err_ovf    = err_ovf_reg;
  assign err_unf    = err_unf_reg;
  assign err_sticky = err_sticky_reg;
  assign lot_full   = &full;

endmodule

// File: tb/tb_parking_zone_counter.sv
// Directed and scoreboard-checked bench for parking_zone_counter at default
// parameters (4 zones, 5-bit counts, capacity 25, warning at 20).
module tb_parking_zone_counter;

  localparam int NZ = 4;
  localparam int W  = 5;
  localparam int C  = 25;
  localparam int WR = 20;

  logic           CLOCK_50 = 1'b0;
  logic           RSTN;
  logic [NZ-1:0]  INC, DEC;
  logic           CLR, LOAD_EN;
  logic [1:0]     LOAD_ZONE;
  logic [W-1:0]   LOAD_VAL;
  logic [NZ*W-1:0] cntNum;
  logic [6:0]     total;
  logic [NZ-1:0]  full, empty, warn, err_ovf, err_unf;
  logic           lot_full, err_sticky;

  int tests_run    = 0;
  int tests_failed = 0;

  int       m_cnt [NZ];
  logic [NZ-1:0] m_ovf, m_unf;
  logic     m_sticky;

  parking_zone_counter dut (
    .CLOCK_50(CLOCK_50), .RSTN(RSTN), .INC(INC), .DEC(DEC), .CLR(CLR),
    .LOAD_EN(LOAD_EN), .LOAD_ZONE(LOAD_ZONE), .LOAD_VAL(LOAD_VAL),
    .cntNum(cntNum), .total(total), .full(full), .empty(empty), .warn(warn),
    .lot_full(lot_full), .err_ovf(err_ovf), .err_unf(err_unf), .err_sticky(err_sticky)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int zc(input int z);
    return int'(cntNum[z*W +: W]);
  endfunction

  task automatic idle();
    INC = '0; DEC = '0; CLR = 1'b0; LOAD_EN = 1'b0; LOAD_ZONE = '0; LOAD_VAL = '0;
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    $display("[TB] t=%0t INC=%b DEC=%b CLR=%b LD=%b/%0d/%0d cnt=%h total=%0d ovf=%b unf=%b st=%b",
             $time, INC, DEC, CLR, LOAD_EN, LOAD_ZONE, LOAD_VAL, cntNum, total,
             err_ovf, err_unf, err_sticky);
  endtask

  task automatic load(input int z, input int v);
    idle(); LOAD_EN = 1'b1; LOAD_ZONE = 2'(z); LOAD_VAL = 5'(v);
    step();
    idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnt"}, 64'(cntNum), 64'd0);
    check({tag, "_total"}, 64'(total), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'hF);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_warn"}, 64'(warn), 64'd0);
    check({tag, "_lotfull"}, 64'(lot_full), 64'd0);
    check({tag, "_err"}, 64'({err_ovf, err_unf, err_sticky}), 64'd0);
  endtask

  task automatic model_step();
    logic [NZ-1:0] ovf, unf;
    ovf = '0; unf = '0;
    if (CLR) begin
      for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
      m_sticky = 1'b0;
    end else begin
      if (LOAD_EN && int'(LOAD_VAL) > C) m_sticky = 1'b1;
      for (int z = 0; z < NZ; z++) begin
        if (LOAD_EN && int'(LOAD_ZONE) == z)
          m_cnt[z] = (int'(LOAD_VAL) > C) ? C : int'(LOAD_VAL);
        else if (INC[z] && !DEC[z]) begin
          if (m_cnt[z] == C) ovf[z] = 1'b1; else m_cnt[z]++;
        end else if (DEC[z] && !INC[z]) begin
          if (m_cnt[z] == 0) unf[z] = 1'b1; else m_cnt[z]--;
        end
      end
      if (ovf != 0 || unf != 0) m_sticky = 1'b1;
    end
    m_ovf = ovf; m_unf = unf;
  endtask

  task automatic model_compare();
    logic [NZ*W-1:0] ecnt;
    logic [NZ-1:0]   ef, ee, ew;
    int              et;
    et = 0;
    for (int z = 0; z < NZ; z++) begin
      ecnt[z*W +: W] = 5'(m_cnt[z]);
      et += m_cnt[z];
      ef[z] = (m_cnt[z] == C);
      ee[z] = (m_cnt[z] == 0);
      ew[z] = (m_cnt[z] >= WR);
    end
    check("rnd_cnt", 64'(cntNum), 64'(ecnt));
    check("rnd_total", 64'(total), 64'(et));
    check("rnd_flags", 64'({full, empty, warn, lot_full}), 64'({ef, ee, ew, &ef}));
    check("rnd_err", 64'({err_ovf, err_unf, err_sticky}), 64'({m_ovf, m_unf, m_sticky}));
  endtask

  initial begin
    idle();
    RSTN = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_reset_state("reset");
    RSTN = 1'b1;

    // Fill zone 0 to capacity, then one refused increment.
    INC = 4'b0001;
    repeat (25) step();
    check("fill_cnt0", 64'(zc(0)), 64'd25);
    check("fill_full", 64'(full), 64'b0001);
    check("fill_total", 64'(total), 64'd25);
    check("fill_warn", 64'(warn), 64'b0001);
    check("fill_sticky0", 64'(err_sticky), 64'd0);
    step();
    check("ovf_pulse", 64'(err_ovf), 64'b0001);
    check("ovf_cnt0", 64'(zc(0)), 64'd25);
    check("ovf_sticky", 64'(err_sticky), 64'd1);
    idle(); step();
    check("ovf_gone", 64'(err_ovf), 64'd0);
    check("ovf_sticky_hold", 64'(err_sticky), 64'd1);
    CLR = 1'b1; step(); idle();
    check("clr_cnt", 64'(cntNum), 64'd0);
    check("clr_sticky", 64'(err_sticky), 64'd0);

    // Underflow at zero, back-to-back, then simultaneous INC/DEC.
    DEC = 4'b0101; step();
    check("unf_pulse1", 64'(err_unf), 64'b0101);
    check("unf_cnt", 64'(cntNum), 64'd0);
    step();
    check("unf_pulse2", 64'(err_unf), 64'b0101);
    check("unf_sticky", 64'(err_sticky), 64'd1);
    INC = 4'b0001; DEC = 4'b0001; step();
    check("incdec_unf", 64'(err_unf | err_ovf), 64'd0);
    check("incdec_cnt", 64'(cntNum), 64'd0);
    idle(); CLR = 1'b1; step(); idle();

    // Load beats INC on the same zone; other zones still count.
    load(2, 24);
    check("ld_cnt2", 64'(zc(2)), 64'd24);
    LOAD_EN = 1'b1; LOAD_ZONE = 2'd2; LOAD_VAL = 5'd10; INC = 4'b0110; step(); idle();
    check("ld_pri_cnt2", 64'(zc(2)), 64'd10);
    check("ld_pri_cnt1", 64'(zc(1)), 64'd1);
    check("ld_pri_total", 64'(total), 64'd11);
    check("ld_pri_sticky", 64'(err_sticky), 64'd0);

    // Over-capacity preset clamps, then CLR outranks everything.
    load(3, 31);
    check("clamp_cnt3", 64'(zc(3)), 64'd25);
    check("clamp_sticky", 64'(err_sticky), 64'd1);
    check("clamp_total", 64'(total), 64'd36);
    CLR = 1'b1; INC = 4'b1111; LOAD_EN = 1'b1; LOAD_ZONE = 2'd0; LOAD_VAL = 5'd7; step(); idle();
    check("clrpri_cnt", 64'(cntNum), 64'd0);
    check("clrpri_total", 64'(total), 64'd0);
    check("clrpri_sticky", 64'(err_sticky), 64'd0);

    // Whole lot full, then drain zone 1 across the warning threshold.
    for (int z = 0; z < NZ; z++) load(z, 25);
    check("lot_full", 64'(lot_full), 64'd1);
    check("lot_total", 64'(total), 64'd100);
    DEC = 4'b0010; step();
    check("lot_full_drop", 64'(lot_full), 64'd0);
    check("lot_total99", 64'(total), 64'd99);
    check("warn_24", 64'(warn), 64'hF);
    repeat (4) step();
    check("warn_20", 64'(warn), 64'hF);
    step(); idle();
    check("cnt1_19", 64'(zc(1)), 64'd19);
    check("warn_19", 64'(warn), 64'b1101);
    check("total_94", 64'(total), 64'd94);

    // Random traffic against a scoreboard, with asynchronous resets mid-cycle.
    RSTN = 1'b0; #1; RSTN = 1'b1;
    check_reset_state("areset0");
    for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
    m_ovf = '0; m_unf = '0; m_sticky = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      INC = 4'($urandom); DEC = 4'($urandom);
      CLR = ($urandom_range(0, 31) == 0);
      LOAD_EN = ($urandom_range(0, 7) == 0);
      LOAD_ZONE = 2'($urandom);
      LOAD_VAL = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 2));
      model_step();
      step();
      model_compare();
      if (cyc % 50 == 49) begin
        #4 RSTN = 1'b0;
        #1;
        check_reset_state("areset");
        for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
        m_ovf = '0; m_unf = '0; m_sticky = 1'b0;
        #3 RSTN = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
